// File: rtl/spi_pin_conditioner.sv
// Raw SPI pin front end: per-channel synchronizer and persistence filter with edge pulses,
// plus CS framing, an in-frame SCLK bit counter and a byte-boundary tick.
module spi_pin_conditioner #(
  parameter int              NCH         = 3,
  parameter int              SYNC_STAGES = 2,
  parameter int              WAIT_W      = 4,
  parameter int              WAIT_TIME   = 3,
  parameter logic [NCH-1:0]  RESET_VAL   = 3'b010
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] pins_in,
  output logic [NCH-1:0] conditioned,
  output logic [NCH-1:0] pos_pulse,
  output logic [NCH-1:0] neg_pulse,
  output logic           cs_active,
  output logic           frame_start,
  output logic           frame_end,
  output logic [2:0]     bit_count,
  output logic           byte_tick
);

  localparam logic [WAIT_W-1:0] LP_WAIT = WAIT_W'(WAIT_TIME);

  logic [NCH-1:0]    r_sync [SYNC_STAGES];
  logic [NCH-1:0]    w_synced;
  logic [WAIT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]    r_cond;
  logic [NCH-1:0]    r_pos;
  logic [NCH-1:0]    r_neg;
  logic [2:0]        r_bit_count;
  logic              r_byte_tick;

  // Synchronizer chain: only stage 0 ever looks at the raw pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_VAL;
    end else begin
      r_sync[0] <= pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Persistence filter: a mismatch must survive WAIT_TIME+1 consecutive cycles to be accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_cond <= RESET_VAL;
      r_pos  <= '0;
      r_neg  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_pos[i] <= 1'b0;
        r_neg[i] <= 1'b0;
        if (w_synced[i] == r_cond[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_WAIT) begin
          r_cond[i] <= w_synced[i];
          r_cnt[i]  <= '0;
          r_pos[i]  <= w_synced[i];
          r_neg[i]  <= ~w_synced[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Frame tracking works on the registered pulses; frame_start wins over a coincident SCLK rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_count <= 3'd0;
      r_byte_tick <= 1'b0;
    end else if (r_neg[1]) begin
      r_bit_count <= 3'd0;
      r_byte_tick <= 1'b0;
    end else if (r_pos[0] && !r_cond[1] && !r_pos[1]) begin
      r_bit_count <= r_bit_count + 3'd1;
      r_byte_tick <= (r_bit_count == 3'd7);
    end else begin
      r_byte_tick <= 1'b0;
    end
  end

  assign conditioned = r_cond;
  assign pos_pulse   = r_pos;
  assign neg_pulse   = r_neg;
  assign cs_active   = ~r_cond[1];
  assign frame_start = r_neg[1];
  assign frame_end   = r_pos[1];
  assign bit_count   = r_bit_count;
  assign byte_tick   = r_byte_tick;

endmodule

// File: doc/spi_pin_conditioner.md
Name: spi_pin_conditioner

Overview:
- Upstream front end for the SPI memory slave. Takes raw asynchronous GPIO pins (SCLK, CS, MOSI) and produces glitch-filtered levels plus single-cycle edge pulses in the clk domain.
- Adds frame tracking: CS framing pulses, an in-frame bit counter and a byte-boundary tick. The downstream slave FSM consumes these and never touches raw pins.

Parameters:
- NCH, 3, number of conditioned channels; ch0=SCLK, ch1=CS, ch2=MOSI (fixed mapping, extra channels filtered only).
- SYNC_STAGES, 2, synchronizer flip-flop depth per channel (>=2).
- WAIT_W, 4, width of the per-channel filter counter.
- WAIT_TIME, 3, cycles a synchronized change must persist beyond the first mismatch cycle before acceptance (0..2^WAIT_W-1).
- RESET_VAL, 3'b010, reset level of synchronizers and conditioned outputs (CS idles high).

Ports:
- clk  in  1  system clock; all outputs registered on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pins_in  in  NCH  raw asynchronous pin levels.
- conditioned  out  NCH  filtered pin levels.
- pos_pulse  out  NCH  one-cycle pulse when conditioned[i] rises.
- neg_pulse  out  NCH  one-cycle pulse when conditioned[i] falls.
- cs_active  out  1  equals ~conditioned[1].
- frame_start  out  1  equals neg_pulse[1].
- frame_end  out  1  equals pos_pulse[1].
- bit_count  out  3  SCLK rising edges counted in the current frame, mod 8.
- byte_tick  out  1  one-cycle pulse when bit_count wraps 7->0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - sync chain and conditioned = RESET_VAL.
  - All filter counters = 0.
  - pos_pulse, neg_pulse, bit_count, byte_tick = 0.
  - cs_active = 0, because conditioned[1] resets to 1.
- Synchronizer: SYNC_STAGES-deep shift chain per channel. synced[i] is the last stage. No logic reads pins_in except the first stage.
- Filter, per channel, each cycle:
  - If synced == conditioned: counter <= 0.
  - Else if counter == WAIT_TIME: conditioned <= synced, counter <= 0, and the matching pulse is registered the same edge.
  - Else: counter <= counter + 1.
  - Result: a synced level held for WAIT_TIME+1 consecutive cycles is accepted. A shorter excursion is rejected and its counter is cleared.
- Latency: a clean pin step sampled at edge 1 changes conditioned at edge SYNC_STAGES+WAIT_TIME+1 (edge 6 with defaults). The pulse is high for exactly the cycle following that edge.
- WAIT_TIME = 0: conditioned follows synced with 1 extra cycle of delay.
- pos_pulse and neg_pulse are never both high on the same channel. Channels are fully independent.
- Frame counter:
  - On frame_start: bit_count <= 0, byte_tick <= 0.
  - On pos_pulse[0] while cs_active is already 1 and frame_end is not asserted that cycle: bit_count <= bit_count + 1, and byte_tick <= 1 iff the old bit_count == 7.
  - Otherwise: bit_count holds and byte_tick <= 0.
- Frame counter, simultaneous events:
  - SCLK rise with frame_start in the same cycle: bit_count = 0, no tick.
  - SCLK rise with frame_end in the same cycle: ignored.
  - SCLK rises while CS is inactive: ignored, bit_count unchanged.
- bit_count retains its value after frame_end until the next frame_start.
- No handshake: outputs are level/pulse only, and the consumer must sample every cycle.

Test Plan:
- Reset then idle with pins_in=3'b010 for 20 cycles -> conditioned=3'b010; all pulses 0; cs_active=0; bit_count=0.
- Step pins_in[2] 0->1 at edge 1 (defaults) -> conditioned[2] rises at edge 6; pos_pulse[2] high for exactly one cycle; other channels unchanged.
- 3-cycle high glitch on pins_in[0] -> no change in conditioned[0], no pulse. 4-cycle high pulse -> accepted, then a falling transition 4 cycles later.
- CS low, 16 clean SCLK rise/fall cycles (SCLK half-period 10 clk), CS high:
  - frame_start is one pulse.
  - bit_count runs 1..7,0,1..7,0.
  - byte_tick pulses twice, each coinciding with the 7->0 wrap.
  - frame_end is one pulse; bit_count then holds at 0.
- SCLK edges while CS high -> bit_count stays 0, no byte_tick. Then drive CS-fall and SCLK-rise filtered in the same cycle -> bit_count = 0, no tick.
- Assert reset mid-frame (bit_count=5, cs_active=1) asynchronously between clock edges -> outputs return to reset values immediately. After release with pins held, conditioned re-acquires the pin levels after SYNC_STAGES+WAIT_TIME+1 cycles.
